// File: rtl/queue_arbiter_pkg.sv
// Shared definitions for the queue arbiter: channel-index width helper and
// full-queue policy encodings.
package queue_arbiter_pkg;

  // Full-queue policy values for the DROP parameter.
  localparam int unsigned DropBackpressure = 0;
  localparam int unsigned DropDiscard      = 1;

  // Channel index width: clog2 of the channel count, never narrower than 1 bit.
  // Callers bind CHBITS = ch_bits(NCH).
  function automatic int unsigned ch_bits(input int unsigned nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible channel searching upward from ptr + 1,
// wrapping modulo NCH. Purely combinational.
module rr_pick
  import queue_arbiter_pkg::*;
#(
  parameter  int unsigned NCH    = 4,
  localparam int unsigned CHBITS = ch_bits(NCH)
) (
  input  logic [NCH-1:0]    elig,
  input  logic [CHBITS-1:0] ptr,
  output logic              found,
  output logic [CHBITS-1:0] idx
);

  // Walk offsets 1..NCH from the pointer; the outer loop order sets priority.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (!found && elig[c] && (((32'(ptr) + k) % NCH) == c)) begin
          found = 1'b1;
          idx   = CHBITS'(c);
        end
      end
    end
  end

endmodule

// File: rtl/queue_arbiter.sv
// Round-robin arbiter feeding a downstream queue. Tracks queue occupancy
// locally, and either backpressures or drops requests when the queue is full.
module queue_arbiter
  import queue_arbiter_pkg::*;
#(
  parameter  int unsigned NCH    = 4,
  parameter  int unsigned DBITS  = 8,
  parameter  int unsigned PTBITS = 8,
  parameter  int unsigned DROP   = DropBackpressure,
  localparam int unsigned CHBITS = ch_bits(NCH)
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NCH-1:0]          req,
  input  logic [NCH*DBITS-1:0]    data,
  output logic [NCH-1:0]          ack,
  output logic [CHBITS+DBITS-1:0] q_in,
  output logic                    q_ld,
  input  logic                    q_pp,
  input  logic                    q_em,
  output logic [PTBITS-1:0]       count,
  output logic                    full,
  output logic                    ovf,
  output logic [15:0]             drop_cnt,
  input  logic                    clr
);

  logic [NCH-1:0]          elig;
  logic                    found;
  logic [CHBITS-1:0]       pick;
  logic                    grant, stall, drop, load, pop, underflow;
  logic [DBITS-1:0]        sample;

  logic [NCH-1:0]          ack_q, ack_d;
  logic [CHBITS+DBITS-1:0] q_in_q, q_in_d;
  logic                    q_ld_q, q_ld_d;
  logic [PTBITS-1:0]       count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic [CHBITS-1:0]       ptr_q, ptr_d;

  // A channel whose ack is already out is still holding req; skip it.
  assign elig = req & ~ack_q;

  rr_pick #(
    .NCH (NCH)
  ) u_rr_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick)
  );

  assign full      = (count_q == {PTBITS{1'b1}});
  assign grant     = en && found;
  assign stall     = grant && full && (DROP == DropBackpressure);
  assign drop      = grant && full && (DROP == DropDiscard);
  assign load      = grant && !full;
  assign pop       = q_pp && !q_em;
  assign underflow = pop && (count_q == '0);

  // Mux out the selected channel's sample.
  always_comb begin
    sample = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (pick == CHBITS'(i)) sample = data[i*DBITS +: DBITS];
    end
  end

  // Next-state: grant/drop decode, occupancy accounting, sticky fault flags.
  always_comb begin
    ack_d      = '0;
    q_ld_d     = load;
    q_in_d     = q_in_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    for (int unsigned i = 0; i < NCH; i++) begin
      ack_d[i] = (load || drop) && (pick == CHBITS'(i));
    end
    if (load || drop) ptr_d = pick;
    if (load) q_in_d = {pick, sample};

    // Reservation on load, release on a real pop; both together cancel.
    if (load && !pop) begin
      count_d = count_q + PTBITS'(1);
    end else if (pop && !load && (count_q != '0)) begin
      count_d = count_q - PTBITS'(1);
    end

    if (stall || drop || underflow) ovf_d = 1'b1;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;

    if (clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // State registers; reset also discards any in-flight grant.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      ack_q      <= '0;
      q_in_q     <= '0;
      q_ld_q     <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      ptr_q      <= CHBITS'(NCH - 1);
    end else begin
      ack_q      <= ack_d;
      q_in_q     <= q_in_d;
      q_ld_q     <= q_ld_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign ack      = ack_q;
  assign q_in     = q_in_q;
  assign q_ld     = q_ld_q;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_queue_arbiter.sv
// Directed bench for queue_arbiter: one default instance, plus two small
// 2-bit-pointer instances for the backpressure and drop policies.
module tb_queue_arbiter;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DBITS = 8;

  logic                 ck = 1'b0;
  logic                 rst_n, en, clr, q_em;
  logic [NCH*DBITS-1:0] data;
  logic [NCH-1:0]       req_a, req_b, req_c;
  logic                 q_pp_a, q_pp_b, q_pp_c;

  logic [NCH-1:0] ack_a, ack_b, ack_c;
  logic [9:0]     q_in_a, q_in_b, q_in_c;
  logic           q_ld_a, q_ld_b, q_ld_c;
  logic [7:0]     count_a;
  logic [1:0]     count_b, count_c;
  logic           full_a, full_b, full_c;
  logic           ovf_a, ovf_b, ovf_c;
  logic [15:0]    drop_cnt_a, drop_cnt_b, drop_cnt_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ck = ~ck;

  queue_arbiter #(.NCH(NCH), .DBITS(DBITS), .PTBITS(8), .DROP(0)) u_dut_a (
    .ck(ck), .rst_n(rst_n), .en(en), .req(req_a), .data(data), .ack(ack_a),
    .q_in(q_in_a), .q_ld(q_ld_a), .q_pp(q_pp_a), .q_em(q_em), .count(count_a),
    .full(full_a), .ovf(ovf_a), .drop_cnt(drop_cnt_a), .clr(clr)
  );

  queue_arbiter #(.NCH(NCH), .DBITS(DBITS), .PTBITS(2), .DROP(0)) u_dut_b (
    .ck(ck), .rst_n(rst_n), .en(en), .req(req_b), .data(data), .ack(ack_b),
    .q_in(q_in_b), .q_ld(q_ld_b), .q_pp(q_pp_b), .q_em(q_em), .count(count_b),
    .full(full_b), .ovf(ovf_b), .drop_cnt(drop_cnt_b), .clr(clr)
  );

  queue_arbiter #(.NCH(NCH), .DBITS(DBITS), .PTBITS(2), .DROP(1)) u_dut_c (
    .ck(ck), .rst_n(rst_n), .en(en), .req(req_c), .data(data), .ack(ack_c),
    .q_in(q_in_c), .q_ld(q_ld_c), .q_pp(q_pp_c), .q_em(q_em), .count(count_c),
    .full(full_c), .ovf(ovf_c), .drop_cnt(drop_cnt_c), .clr(clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; q_em = 1'b0; data = '0;
    req_a = '0; req_b = '0; req_c = '0;
    q_pp_a = 1'b0; q_pp_b = 1'b0; q_pp_c = 1'b0;
    tick(); tick();

    // Reset state
    check_eq("rst_ack",   32'(ack_a), 0);
    check_eq("rst_q_ld",  32'(q_ld_a), 0);
    check_eq("rst_q_in",  32'(q_in_a), 0);
    check_eq("rst_count", 32'(count_a), 0);
    check_eq("rst_full",  32'(full_a), 0);
    check_eq("rst_ovf",   32'(ovf_a), 0);
    check_eq("rst_drop",  32'(drop_cnt_a), 0);
    check_eq("rst_full_b", 32'(full_b), 0);
    rst_n = 1'b1;

    // Single requester on channel 2
    data  = 32'h00A5_5A3C;
    req_a = 4'b0100;
    tick();
    check_eq("ch2_ack",   32'(ack_a), 32'h4);
    check_eq("ch2_q_ld",  32'(q_ld_a), 1);
    check_eq("ch2_q_in",  32'(q_in_a), 32'h2A5);
    check_eq("ch2_count", 32'(count_a), 1);
    req_a = '0;
    tick();
    check_eq("ch2_q_ld_pulse", 32'(q_ld_a), 0);
    check_eq("ch2_ack_pulse",  32'(ack_a), 0);
    check_eq("ch2_q_in_hold",  32'(q_in_a), 32'h2A5);
    tick();
    check_eq("ch2_q_ld_once",  32'(q_ld_a), 0);
    check_eq("ch2_count_hold", 32'(count_a), 1);

    // Grant enable low suppresses grants
    en    = 1'b0;
    req_a = 4'b0001;
    tick();
    check_eq("en0_ack",  32'(ack_a), 0);
    check_eq("en0_q_ld", 32'(q_ld_a), 0);
    tick();
    check_eq("en0_count", 32'(count_a), 1);
    en = 1'b1;
    tick();
    check_eq("en1_ack",   32'(ack_a), 32'h1);
    check_eq("en1_q_in",  32'(q_in_a), 32'h03C);
    check_eq("en1_count", 32'(count_a), 2);

    // Grant and valid pop on the same edge at count 2
    req_a  = 4'b0010;
    q_pp_a = 1'b1;
    tick();
    check_eq("gp_ack",   32'(ack_a), 32'h2);
    check_eq("gp_q_in",  32'(q_in_a), 32'h15A);
    check_eq("gp_count", 32'(count_a), 2);
    req_a = '0;
    q_em  = 1'b1;
    tick();
    check_eq("pop_em_ignored", 32'(count_a), 2);
    q_em = 1'b0;
    tick();
    check_eq("pop_count", 32'(count_a), 1);
    q_pp_a = 1'b0;

    // Reset the cycle after a grant
    req_a = 4'b1000;
    tick();
    check_eq("pre_rst_ack", 32'(ack_a), 32'h8);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_q_ld",  32'(q_ld_a), 0);
    check_eq("mid_rst_ack",   32'(ack_a), 0);
    check_eq("mid_rst_count", 32'(count_a), 0);
    tick();
    rst_n = 1'b1;
    data  = 32'h4433_2211;
    req_a = 4'b1111;

    // All four requesting: strict rotation starting at channel 0
    for (int i = 0; i < 8; i++) begin
      int unsigned ch;
      ch = i % 4;
      tick();
      check_eq($sformatf("rr_ack_%0d", i), 32'(ack_a), 32'(1) << ch);
      check_eq($sformatf("rr_q_in_%0d", i), 32'(q_in_a), (ch << 8) | (32'h11 * (ch + 1)));
    end
    req_a = '0;
    tick();
    check_eq("rr_count", 32'(count_a), 8);

    // Pop at count 0 is an accounting fault
    rst_n = 1'b0;
    #1;
    rst_n  = 1'b1;
    q_pp_a = 1'b1;
    tick();
    check_eq("uf_count", 32'(count_a), 0);
    check_eq("uf_ovf",   32'(ovf_a), 1);
    q_pp_a = 1'b0;
    clr    = 1'b1;
    tick();
    check_eq("uf_clr_ovf", 32'(ovf_a), 0);
    clr = 1'b0;

    // Backpressure policy, 2-bit pointer
    req_b = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("bp_fill_ack_%0d", i), 32'(ack_b), 32'(1) << i);
      req_b = req_b & ~ack_b;
    end
    check_eq("bp_count3", 32'(count_b), 3);
    check_eq("bp_full",   32'(full_b), 1);
    tick();
    check_eq("bp_stall_ack",  32'(ack_b), 0);
    check_eq("bp_stall_q_ld", 32'(q_ld_b), 0);
    check_eq("bp_ovf",        32'(ovf_b), 1);
    check_eq("bp_stall_cnt",  32'(count_b), 3);
    q_pp_b = 1'b1;
    tick();
    check_eq("bp_pop_count", 32'(count_b), 2);
    check_eq("bp_pop_full",  32'(full_b), 0);
    check_eq("bp_pop_ack",   32'(ack_b), 0);
    q_pp_b = 1'b0;
    tick();
    check_eq("bp_late_ack",  32'(ack_b), 32'h8);
    check_eq("bp_late_q_ld", 32'(q_ld_b), 1);
    check_eq("bp_late_q_in", 32'(q_in_b), 32'h344);
    check_eq("bp_late_cnt",  32'(count_b), 3);
    check_eq("bp_no_drops",  32'(drop_cnt_b), 0);
    req_b = '0;

    // Drop policy, 2-bit pointer
    req_c = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("dr_fill_ack_%0d", i), 32'(ack_c), 32'(1) << i);
      req_c = req_c & ~ack_c;
    end
    check_eq("dr_full", 32'(full_c), 1);
    req_c = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      logic [3:0] exp_ack [3];
      exp_ack[0] = 4'b1000;
      exp_ack[1] = 4'b0001;
      exp_ack[2] = 4'b0010;
      tick();
      check_eq($sformatf("dr_ack_%0d", i),  32'(ack_c), 32'(exp_ack[i]));
      check_eq($sformatf("dr_q_ld_%0d", i), 32'(q_ld_c), 0);
    end
    check_eq("dr_drop_cnt", 32'(drop_cnt_c), 3);
    check_eq("dr_ovf",      32'(ovf_c), 1);
    check_eq("dr_count",    32'(count_c), 3);
    check_eq("dr_q_in",     32'(q_in_c), 32'h233);
    // Clear wins over a same-edge drop
    clr = 1'b1;
    tick();
    check_eq("dr_clr_ack",  32'(ack_c), 32'h4);
    check_eq("dr_clr_drop", 32'(drop_cnt_c), 0);
    check_eq("dr_clr_ovf",  32'(ovf_c), 0);
    clr   = 1'b0;
    req_c = '0;
    tick();
    check_eq("dr_after_drop", 32'(drop_cnt_c), 0);
    check_eq("dr_after_q_ld", 32'(q_ld_c), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/queue_arbiter.md
QUEUE_ARBITER -- requirements
Module: queue_arbiter

Interface
REQ-001 The block SHALL have parameters: NCH, default 4, number of requesting channels (2..16); DBITS, default 8, sample width; PTBITS, default 8, downstream queue pointer width; DROP, default 0, full-queue policy (0 = backpressure, 1 = drop).
REQ-002 ck  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 en  input  1  grant enable; when low no new grants are issued.
REQ-005 req  input  NCH  per-channel request; held high with its data slice stable until acked.
REQ-006 data  input  NCH*DBITS  channel samples; channel i occupies bits [i*DBITS +: DBITS].
REQ-007 ack  output  NCH  one-cycle grant/consume pulse per channel.
REQ-008 q_in  output  CHBITS+DBITS  queue write word: {channel index, sample}.
REQ-009 q_ld  output  1  queue load strobe.
REQ-010 q_pp  input  1  pop strobe driven by the queue consumer (observed, not driven).
REQ-011 q_em  input  1  queue empty flag.
REQ-012 count  output  PTBITS  queue occupancy as tracked by this block.
REQ-013 full  output  1  high when count == 2**PTBITS-1.
REQ-014 ovf  output  1  sticky: a request was dropped (DROP=1) or stalled by full (DROP=0).
REQ-015 drop_cnt  output  16  number of dropped samples, saturating at 16'hFFFF.
REQ-016 clr  input  1  synchronous clear of ovf and drop_cnt.

Function
REQ-017 Eligible channels at an edge: req[i]=1 and ack[i]=0; at most one grant per edge.
REQ-018 Selection SHALL be round-robin: search starts at last granted index + 1, mod NCH; after reset the search starts at channel 0.
REQ-019 On a grant to channel i with full=0: ack[i], q_ld and q_in={i, data slice i} SHALL be registered and valid in the next cycle; latency req-to-q_ld is 1 cycle.
REQ-020 q_ld and ack SHALL be high for exactly one cycle per grant; q_in holds its last value when q_ld=0.
REQ-021 count SHALL increment on the edge that registers q_ld=1 (reservation), and decrement on an edge with q_pp=1 and q_em=0.
REQ-022 Simultaneous increment and decrement SHALL leave count unchanged; count never wraps.
REQ-023 A valid pop with count=0 SHALL leave count at 0 and set ovf, as an accounting fault.
REQ-024 When full=1 and DROP=0: no grant; a pending eligible request sets ovf; the round-robin pointer does not advance.
REQ-025 When full=1 and DROP=1: the selected channel is acked, q_ld stays 0, drop_cnt increments (saturating), ovf sets, and the pointer advances.
REQ-026 en=0 SHALL suppress grants without affecting count, popping or ovf/drop_cnt state.
REQ-027 clr SHALL take priority over a same-edge ovf set or drop_cnt increment.

Reset
REQ-028 While rst_n=0: ack=0, q_ld=0, q_in=0, count=0, full=0, ovf=0, drop_cnt=0, round-robin pointer = NCH-1 (next search from channel 0).
REQ-029 A reset mid-operation SHALL discard any registered in-flight grant; the downstream queue is reset by the same rst_n.

Structure
REQ-030 A shared package SHALL hold CHBITS = clog2(NCH) (minimum 1) and the DROP policy constants.
REQ-031 The round-robin selection SHALL be one combinational sub-module, rr_pick (inputs: eligible mask, pointer; outputs: found, index).
REQ-032 The block SHALL pair with a queue of NBITS = CHBITS+DBITS and the same PTBITS, sharing ck and rst_n.

Verification
REQ-033 All four channels request continuously, 8 grants -> ack order 0,1,2,3,0,1,2,3; q_in channel field matches each ack.
REQ-034 Only channel 2 requests with data 8'hA5, holding req until ack -> exactly one q_ld, q_in={2'd2,8'hA5}, count=1.
REQ-035 PTBITS=2, DROP=0: 4 requests, no pops -> count reaches 3, full=1, 4th request stalls, ovf=1; one pop -> 4th granted next edge.
REQ-036 PTBITS=2, DROP=1, full: 3 further requests -> 3 acks, no q_ld, drop_cnt=3; clr -> drop_cnt=0, ovf=0.
REQ-037 Grant and valid pop on the same edge at count=2 -> count stays 2.
REQ-038 rst_n asserted the cycle after a grant -> q_ld, ack and count are 0 immediately; after release the first grant goes to channel 0.
